// File: rtl/pio_input_debouncer_if.sv
// Signal bundle between the board-input debouncer and the PIO in_port / edge logic.
// The slave modport is the debouncer side; the master modport is the board/consumer side.
interface pio_input_debouncer_if #(
    parameter int WIDTH = 21
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] clean_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             change_any;
    logic             sample_tick;

    modport master (
        output raw_in,
        input  clean_out,
        input  rise_pulse,
        input  fall_pulse,
        input  change_any,
        input  sample_tick
    );

    modport slave (
        input  raw_in,
        output clean_out,
        output rise_pulse,
        output fall_pulse,
        output change_any,
        output sample_tick
    );
endinterface

// File: rtl/pio_input_debouncer.sv
// Two-flop synchronizer plus per-bit tick-sampled debounce for the PIO input bus,
// with registered one-cycle rise/fall/change pulses aligned to clean_out updates.
module pio_input_debouncer #(
    parameter int               WIDTH        = 21,
    parameter int               TICK_DIV     = 50000,
    parameter int               STABLE_TICKS = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input logic                 clk,
    input logic                 reset_n,
    pio_input_debouncer_if.slave bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0]         s1_q, s1_d;
    logic [WIDTH-1:0]         s2_q, s2_d;
    logic [PW-1:0]            presc_q, presc_d;
    logic                     tick_q, tick_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         clean_q, clean_d;
    logic [WIDTH-1:0]         rise_q, rise_d;
    logic [WIDTH-1:0]         fall_q, fall_d;
    logic                     change_q, change_d;

    always_comb begin
        s1_d     = bus.raw_in;
        s2_d     = s1_q;
        presc_d  = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        tick_d   = (presc_q == PRESC_LAST);
        cnt_d    = cnt_q;
        clean_d  = clean_q;
        rise_d   = '0;
        fall_d   = '0;
        // A sample equal to the clean level restarts the count, so glitches never accumulate.
        if (tick_q) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2_q[i] == clean_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = s2_q[i];
                    cnt_d[i]   = '0;
                    rise_d[i]  = s2_q[i];
                    fall_d[i]  = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        change_d = |{rise_d, fall_d};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            cnt_q    <= '0;
            clean_q  <= RESET_VALUE;
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            cnt_q    <= cnt_d;
            clean_q  <= clean_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
        end
    end

    assign bus.clean_out   = clean_q;
    assign bus.rise_pulse  = rise_q;
    assign bus.fall_pulse  = fall_q;
    assign bus.change_any  = change_q;
    assign bus.sample_tick = tick_q;

endmodule

// File: tb/tb_pio_input_debouncer.sv
// Bench for pio_input_debouncer: instance A (TICK_DIV=4, STABLE_TICKS=3) checked every cycle
// against a sample-window model; instance B (TICK_DIV=1, STABLE_TICKS=4) for exact latency.
module tb_pio_input_debouncer;

    localparam int W    = 21;
    localparam int TD_A = 4;
    localparam int ST_A = 3;
    localparam logic [W-1:0] RV_B = 21'h000100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pio_input_debouncer_if #(.WIDTH(W)) bus_a ();
    pio_input_debouncer_if #(.WIDTH(W)) bus_b ();

    pio_input_debouncer #(
        .WIDTH(W), .TICK_DIV(TD_A), .STABLE_TICKS(ST_A), .RESET_VALUE('0)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );

    pio_input_debouncer #(
        .WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(4), .RESET_VALUE(RV_B)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: clean flips a bit when the last ST_A tick samples since reset all
    // differ from it; ticks fall every TD_A edges after release; input seen 2 edges late.
    logic [W-1:0] m_s1, m_s2, m_clean, m_rise, m_fall;
    logic         m_tick, m_chg;
    int           m_edges;
    logic [W-1:0] samp_q[$];

    int n_chg_seen;
    int n_rise_all;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
        m_tick = 1'b0; m_chg = 1'b0; m_edges = 0;
        samp_q.delete();
    endtask

    task automatic model_edge();
        logic [W-1:0] new_clean;
        logic         all_differ;
        if (!reset_n) begin
            model_reset();
        end else begin
            new_clean = m_clean;
            m_rise = '0;
            m_fall = '0;
            if (m_tick) begin
                samp_q.push_back(m_s2);
                if (samp_q.size() > ST_A) void'(samp_q.pop_front());
                if (samp_q.size() == ST_A) begin
                    for (int b = 0; b < W; b++) begin
                        all_differ = 1'b1;
                        foreach (samp_q[j]) if (samp_q[j][b] == m_clean[b]) all_differ = 1'b0;
                        if (all_differ) begin
                            new_clean[b] = ~m_clean[b];
                            m_rise[b] = ~m_clean[b];
                            m_fall[b] = m_clean[b];
                        end
                    end
                end
            end
            m_clean = new_clean;
            m_chg = |(m_rise | m_fall);
            m_s2 = m_s1;
            m_s1 = bus_a.raw_in;
            m_edges++;
            m_tick = (m_edges % TD_A) == 0;
        end
    endtask

    function automatic int differ_count(input int b);
        int c = 0;
        for (int j = samp_q.size() - 1; j >= 0; j--) begin
            if (samp_q[j][b] == m_clean[b]) break;
            c++;
        end
        return c;
    endfunction

    task automatic compare_a();
        check("clean", bus_a.clean_out, m_clean);
        check("rise", bus_a.rise_pulse, m_rise);
        check("fall", bus_a.fall_pulse, m_fall);
        check("change", bus_a.change_any, m_chg);
        check("tick", bus_a.sample_tick, m_tick);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            model_edge();
            compare_a();
            if (bus_a.change_any) n_chg_seen++;
            if (bus_a.rise_pulse == 21'h1FFFFF) n_rise_all++;
        end
    endtask

    task automatic assert_reset();
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_a();
    endtask

    initial begin
        int lat;
        bus_a.raw_in = 21'h1FFFFF;
        bus_b.raw_in = RV_B;
        model_reset();

        // Reset behaviour
        #1;
        compare_a();
        step(3);
        check("b_reset_clean", bus_b.clean_out, RV_B);
        check("b_reset_rise", bus_b.rise_pulse, 0);
        reset_n = 1'b1;
        n_chg_seen = 0;
        n_rise_all = 0;
        step(14);
        check("rst_release_clean", bus_a.clean_out, 21'h1FFFFF);
        check("rst_release_rise_cycles", n_rise_all, 1);
        check("rst_release_change_cycles", n_chg_seen, 1);

        // Glitch rejection
        bus_a.raw_in = '0;
        step(20);
        n_chg_seen = 0;
        bus_a.raw_in = 21'h000008;
        step(8);
        bus_a.raw_in = '0;
        step(20);
        check("glitch_change", n_chg_seen, 0);
        check("glitch_clean", bus_a.clean_out, 0);

        // Press then release
        n_chg_seen = 0;
        bus_a.raw_in = 21'h000001;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (lat == 0 && bus_a.clean_out[0]) lat = k;
        end
        check("press_in_time", (lat >= 1 && lat <= 14), 1);
        bus_a.raw_in = '0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (lat == 0 && !bus_a.clean_out[0]) lat = k;
        end
        check("release_in_time", (lat >= 1 && lat <= 14), 1);
        check("press_release_changes", n_chg_seen, 2);

        // Simultaneous bits
        bus_a.raw_in = 21'h100000;
        step(20);
        n_chg_seen = 0;
        bus_a.raw_in = 21'h000020;
        step(20);
        check("simul_clean", bus_a.clean_out, 21'h000020);
        check("simul_change_cycles", n_chg_seen, 1);

        // Exact latency on instance B
        bus_b.raw_in = RV_B | 21'h000080;
        for (int k = 0; k <= 6; k++) begin
            step(1);
            check($sformatf("b_lat_clean_e%0d", k), bus_b.clean_out[7], (k >= 5));
            check($sformatf("b_lat_rise_e%0d", k), bus_b.rise_pulse[7], (k == 5));
        end

        // Reset mid-count
        bus_a.raw_in = '0;
        step(20);
        bus_a.raw_in = 21'h000004;
        lat = 0;
        for (int k = 0; k < 20 && lat == 0; k++) begin
            step(1);
            if (differ_count(2) == 2) lat = 1;
        end
        check("midcount_reached", lat, 1);
        assert_reset();
        step(2);
        reset_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            if (lat == 0 && bus_a.clean_out[2]) lat = k;
        end
        check("midcount_recount_lat", lat, 13);

        // Randomized chatter, holds and occasional resets
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                assert_reset();
                step($urandom_range(1, 3));
                reset_n = 1'b1;
            end
            case ($urandom_range(0, 15))
                0, 1: bus_a.raw_in[$urandom_range(0, W - 1)] ^= 1'b1;
                2:    bus_a.raw_in = W'($urandom);
                default: ;
            endcase
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pio_input_debouncer.md
Name: pio_input_debouncer

Overview:
Input conditioning stage directly upstream of the 21-bit Avalon PIO input port. It synchronizes asynchronous board inputs (switches and keys) into clk, debounces each bit against a shared sample tick, and presents a glitch-free bus to the PIO in_port. It also emits per-bit one-cycle rise and fall pulses for edge-capture or IRQ logic.

Parameters:
WIDTH, 21, number of input bits; matches the PIO in_port width.
TICK_DIV, 50000, clk cycles per debounce sample tick (1 ms at 50 MHz); legal range is 1 or greater.
STABLE_TICKS, 4, consecutive differing samples required before a bit changes; legal range is 1 or greater.
RESET_VALUE, 0, WIDTH-bit value of clean_out during and after reset.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
raw_in  input  WIDTH  asynchronous board inputs
clean_out  output  WIDTH  debounced bus; drives PIO in_port
rise_pulse  output  WIDTH  per bit, one-cycle pulse on a clean_out 0->1 transition
fall_pulse  output  WIDTH  per bit, one-cycle pulse on a clean_out 1->0 transition
change_any  output  1  one-cycle pulse when any bit of clean_out changes
sample_tick  output  1  one-cycle debounce sample strobe (debug/observability)

Behaviour:
- Reset and clock: reset is reset_n, asynchronous, active-low; clock is clk. While reset is asserted:
  - sync stages = 0, prescaler = 0, all bit counters = 0;
  - clean_out = RESET_VALUE;
  - rise_pulse, fall_pulse, change_any, sample_tick = 0.
- Reset mid-operation: all state returns to reset values immediately. No pulses are emitted by reset assertion or release.
- Synchronizer: two-flop chain, raw_in -> s1 -> s2, for every bit. No other logic reads s1 or raw_in.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0.
  - sample_tick is registered and high for exactly one cycle when the count equals TICK_DIV-1.
  - With TICK_DIV=1, sample_tick is high every cycle after reset release.
- Per-bit debounce, bit i, evaluated only in cycles where sample_tick=1:
  - If s2[i]==clean_out[i]: cnt[i] <= 0 (a glitch that returns to the clean level restarts the count).
  - Else if cnt[i]==STABLE_TICKS-1: clean_out[i] <= s2[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Counter width is clog2(STABLE_TICKS) with a minimum of 1 bit. The counter never exceeds STABLE_TICKS-1.
- Outside tick cycles, all counters and clean_out hold.
- Pulses: rise_pulse[i], fall_pulse[i] and change_any are registered and asserted in the same cycle the new clean_out value first appears, for exactly one cycle.
  - change_any = OR of all rise and fall pulses, aligned with them.
  - Bits are independent. Several bits may update on the same tick and their pulses coincide.
- Latency:
  - From the first edge that samples a stable new raw_in level to clean_out changing: min 2+STABLE_TICKS cycles (TICK_DIV=1), max 2+TICK_DIV*STABLE_TICKS cycles.
  - With TICK_DIV=1 and STABLE_TICKS=4, clean_out updates on exactly the 6th rising edge.
- Boundary cases:
  - STABLE_TICKS=1: a bit updates on the first tick where it differs.
  - A raw change arriving in the same cycle as a tick is seen by the next tick: s2 lags raw_in by 2 cycles.

Test Plan:
1. Reset behaviour (TICK_DIV=4, STABLE_TICKS=3):
   - Stimulus: reset_n low, raw_in=0x1FFFFF.
   - Required: clean_out=0x000000 and all pulses 0 while in reset.
   - After release: clean_out=0x1FFFFF within 2+12 cycles; rise_pulse=0x1FFFFF and change_any=1 for exactly one cycle.
2. Glitch rejection (TICK_DIV=4, STABLE_TICKS=3, clean_out=0):
   - Stimulus: raw_in[3] high for 8 cycles, then low.
   - Required: clean_out stays 0x000000; rise_pulse, fall_pulse and change_any never assert.
3. Press then release:
   - Stimulus: raw_in[0] goes high and holds 20 cycles, then goes low and holds.
   - Required: clean_out[0] goes 1 with a single-cycle rise_pulse=0x000001, later goes 0 with a single-cycle fall_pulse=0x000001.
   - Each transition completes within 14 cycles of the raw edge.
4. Simultaneous bits:
   - Stimulus: from clean_out=0x100000, raw_in becomes 0x000020 in one cycle.
   - Required: both bits update on the same cycle; rise_pulse=0x000020, fall_pulse=0x100000, change_any high for one cycle only.
5. Exact latency (TICK_DIV=1, STABLE_TICKS=4):
   - Stimulus: raw_in[7] rises just before edge 0.
   - Required: clean_out[7]=1 and rise_pulse[7]=1 after edge 5 (6th edge), not before.
6. Reset mid-count:
   - Stimulus: reset_n pulsed low while cnt[2]=2 with raw_in[2]=1.
   - Required: clean_out=RESET_VALUE and no pulse during reset; after release, a full STABLE_TICKS count restarts before clean_out[2]=1.
